// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode map, FSM states, flag bundle and
// the helper that decides whether an op needs the iterative mul/div unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_NOT = 4'b0110,
    OP_SLL = 4'b0111,
    OP_SRL = 4'b1000,
    OP_SRA = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } alu_state_e;

  localparam logic [3:0] OP_LAST = 4'b1001;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic div_zero;
    logic illegal_op;
  } alu_flags_t;

  // Divide by zero short-circuits to a one-cycle result, so only a real divide
  // takes the multi-cycle path.
  function automatic logic is_iterative(logic [3:0] op, logic b_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue and result channels of the sequential ALU, both valid/ready.
// master = issue logic + writeback side, slave = the ALU.
interface alu_seq_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [N-1:0] result_hi;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         div_zero;
  logic         illegal_op;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, result_hi,
           zero, carry, overflow, div_zero, illegal_op
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, result_hi,
           zero, carry, overflow, div_zero, illegal_op
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// lo/hi show the value after the current step and are meaningful while done=1.
module alu_muldiv_iter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi
);
  localparam int SHW = $clog2(N);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(N - 1);

  logic           busy;
  logic           div_q;
  logic [SHW-1:0] cnt;
  logic [N-1:0]   hi_q;     // partial product high half / running remainder
  logic [N-1:0]   lo_q;     // multiplier bits / dividend shifting into quotient
  logic [N-1:0]   opnd_q;   // multiplicand / divisor
  logic [N-1:0]   hi_nxt;
  logic [N-1:0]   lo_nxt;
  logic [N:0]     add_sum;
  logic [N:0]     shifted;
  logic [N:0]     trial;

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hi_nxt  = hi_q;
    lo_nxt  = lo_q;
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[N-1]};
    trial   = shifted - {1'b0, opnd_q};
    if (div_q) begin
      if (trial[N]) begin
        hi_nxt = shifted[N-1:0];
        lo_nxt = {lo_q[N-2:0], 1'b0};
      end else begin
        hi_nxt = trial[N-1:0];
        lo_nxt = {lo_q[N-2:0], 1'b1};
      end
    end else begin
      hi_nxt = add_sum[N:1];
      lo_nxt = {add_sum[0], lo_q[N-1:1]};
    end
  end

  assign done = busy && (cnt == CNT_LAST);
  assign lo   = lo_nxt;
  assign hi   = hi_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      div_q  <= 1'b0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      div_q  <= is_div;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= a;
      opnd_q <= b;
    end else if (busy) begin
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle handshaked ALU: single-cycle ops resolve at accept, MUL/DIV run
// through the iterative unit; the result is held in DONE until consumed.
module alu_seq #(
  parameter int N = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  import alu_pkg::*;

  localparam int SHW = $clog2(N);
  localparam logic [N-1:0] N_VEC = N[N-1:0];

  alu_state_e     state;
  alu_state_e     state_nxt;
  logic           in_ready;
  logic           out_valid;
  logic           accept;
  logic           go_iter;
  logic           div_q;
  logic           iter_done;
  logic [N-1:0]   iter_lo;
  logic [N-1:0]   iter_hi;
  logic [N-1:0]   sc_res;
  logic [N-1:0]   sc_hi;
  alu_flags_t     sc_flags;
  alu_flags_t     iter_flags;
  logic [N-1:0]   res_q;
  logic [N-1:0]   res_hi_q;
  alu_flags_t     flags_q;
  logic [N:0]     add_sum;
  logic [N:0]     sub_diff;
  logic [SHW-1:0] sh;
  logic           big_shift;

  assign accept  = bus.in_valid && in_ready;
  assign go_iter = accept && is_iterative(bus.op, bus.b == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = go_iter ? BUSY : DONE;
      end
      BUSY: if (iter_done) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  alu_muldiv_iter #(.N(N)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (go_iter),
    .is_div (bus.op == OP_DIV),
    .a      (bus.a),
    .b      (bus.b),
    .done   (iter_done),
    .lo     (iter_lo),
    .hi     (iter_hi)
  );

  // Single-cycle datapath, evaluated on the live operands and captured at accept.
  always_comb begin
    sc_res    = '0;
    sc_hi     = '0;
    sc_flags  = '0;
    add_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    sub_diff  = {1'b0, bus.a} - {1'b0, bus.b};
    sh        = bus.b[SHW-1:0];
    big_shift = (bus.b >= N_VEC);
    case (alu_op_e'(bus.op))
      OP_ADD: begin
        sc_res            = add_sum[N-1:0];
        sc_flags.carry    = add_sum[N];
        sc_flags.overflow = (bus.a[N-1] == bus.b[N-1]) && (add_sum[N-1] != bus.a[N-1]);
      end
      OP_SUB: begin
        sc_res            = sub_diff[N-1:0];
        sc_flags.carry    = sub_diff[N];
        sc_flags.overflow = (bus.a[N-1] != bus.b[N-1]) && (sub_diff[N-1] != bus.a[N-1]);
      end
      OP_MUL: ;
      OP_DIV: begin
        // Only reached with b == 0; real divides go through the iterative unit.
        sc_res            = '1;
        sc_hi             = bus.a;
        sc_flags.div_zero = 1'b1;
      end
      OP_AND: sc_res = bus.a & bus.b;
      OP_OR:  sc_res = bus.a | bus.b;
      OP_NOT: sc_res = ~bus.a;
      OP_SLL: sc_res = big_shift ? '0 : (bus.a << sh);
      OP_SRL: sc_res = big_shift ? '0 : (bus.a >> sh);
      OP_SRA: sc_res = big_shift ? {N{bus.a[N-1]}} : N'($signed(bus.a) >>> sh);
      default: sc_flags.illegal_op = 1'b1;
    endcase
    sc_flags.zero = (sc_res == '0) && !sc_flags.illegal_op;
  end

  always_comb begin
    iter_flags       = '0;
    iter_flags.zero  = (iter_lo == '0);
    iter_flags.carry = !div_q && (iter_hi != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      if (accept) div_q <= (bus.op == OP_DIV);
      if (accept && !go_iter) begin
        res_q    <= sc_res;
        res_hi_q <= sc_hi;
        flags_q  <= sc_flags;
      end else if ((state == BUSY) && iter_done) begin
        res_q    <= iter_lo;
        res_hi_q <= iter_hi;
        flags_q  <= iter_flags;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.result     = res_q;
  assign bus.result_hi  = res_hi_q;
  assign bus.zero       = flags_q.zero;
  assign bus.carry      = flags_q.carry;
  assign bus.overflow   = flags_q.overflow;
  assign bus.div_zero   = flags_q.div_zero;
  assign bus.illegal_op = flags_q.illegal_op;

endmodule
